// File: rtl/read_data_router_if.sv
// Bus bundle for the R-channel router: slave-facing inputs, master-facing outputs, error flag.
// Modport master is the router's view; modport slave is the surrounding environment's view.
interface read_data_router_if #(
    parameter int NUM_S     = 6,
    parameter int NUM_M     = 3,
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = 8,
    parameter int DATA_BITS = 32
);
    logic [NUM_S*IDS_BITS-1:0]  RID_S;
    logic [NUM_S*DATA_BITS-1:0] RDATA_S;
    logic [NUM_S*2-1:0]         RRESP_S;
    logic [NUM_S-1:0]           RLAST_S;
    logic [NUM_S-1:0]           RVALID_S;
    logic [NUM_S-1:0]           RREADY_S;
    logic [NUM_M*ID_BITS-1:0]   RID_M;
    logic [NUM_M*DATA_BITS-1:0] RDATA_M;
    logic [NUM_M*2-1:0]         RRESP_M;
    logic [NUM_M-1:0]           RLAST_M;
    logic [NUM_M-1:0]           RVALID_M;
    logic [NUM_M-1:0]           RREADY_M;
    logic                       rid_err;

    modport master (
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_M,
        output RREADY_S, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M, rid_err
    );

    modport slave (
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_M,
        input  RREADY_S, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M, rid_err
    );
endinterface

// File: rtl/read_data_router.sv
// AXI R-channel router: per-master round-robin over slaves, grant locked until RLAST handshake; zero-latency path.
// Optional macro RDR_INVALID_DRAIN_EN drains beats with an invalid master field and flags rid_err.
module read_data_router #(
    parameter int NUM_S     = 6,
    parameter int NUM_M     = 3,
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = 8,
    parameter int DATA_BITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    read_data_router_if.master bus
);
    localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int FW = IDS_BITS - ID_BITS;

    typedef enum logic {IDLE, LOCKED} st_e;

    st_e              st_q   [NUM_M];
    st_e              st_d   [NUM_M];
    logic [SW-1:0]    lock_q [NUM_M];
    logic [SW-1:0]    lock_d [NUM_M];
    logic [SW-1:0]    rr_q   [NUM_M];
    logic [SW-1:0]    rr_d   [NUM_M];

    logic [NUM_S-1:0] req    [NUM_M];
    logic [NUM_M-1:0] gnt_vld;
    logic [SW-1:0]    gnt_slv [NUM_M];
    logic [NUM_M-1:0] hs_last;
    logic [NUM_S-1:0] busy_s;
    logic [NUM_S-1:0] rdy_s;
    logic [FW-1:0]    fld;
    logic [FW-1:0]    onehot;

    logic [NUM_M*ID_BITS-1:0]   rid_m;
    logic [NUM_M*DATA_BITS-1:0] rdata_m;
    logic [NUM_M*2-1:0]         rresp_m;
    logic [NUM_M-1:0]           rlast_m;
    logic [NUM_M-1:0]           rvalid_m;

`ifdef RDR_INVALID_DRAIN_EN
    logic [NUM_S-1:0] hit_s;
    logic [NUM_S-1:0] drain_s;
    logic             rid_err_q;
`endif

    // Master field must be exactly one-hot on an existing master; anything else never requests.
    always_comb begin
        fld    = '0;
        onehot = '0;
        for (int m = 0; m < NUM_M; m++) req[m] = '0;
`ifdef RDR_INVALID_DRAIN_EN
        hit_s = '0;
`endif
        for (int s = 0; s < NUM_S; s++) begin
            fld = bus.RID_S[s*IDS_BITS+ID_BITS +: FW];
            for (int m = 0; m < NUM_M; m++) begin
                onehot    = '0;
                onehot[m] = 1'b1;
                req[m][s] = bus.RVALID_S[s] && (fld == onehot);
`ifdef RDR_INVALID_DRAIN_EN
                hit_s[s]  = hit_s[s] | req[m][s];
`endif
            end
        end
    end

    // Walk downwards so the slave closest to rr_ptr (wrapping) is the last, winning, assignment.
    always_comb begin
        int idx;
        idx = 0;
        for (int m = 0; m < NUM_M; m++) begin
            gnt_vld[m] = 1'b0;
            gnt_slv[m] = '0;
            if (st_q[m] == LOCKED) begin
                gnt_vld[m] = 1'b1;
                gnt_slv[m] = lock_q[m];
            end else begin
                for (int k = NUM_S - 1; k >= 0; k--) begin
                    idx = int'(rr_q[m]) + k;
                    if (idx >= NUM_S) idx = idx - NUM_S;
                    if (req[m][idx]) begin
                        gnt_vld[m] = 1'b1;
                        gnt_slv[m] = SW'(idx);
                    end
                end
            end
            if (!rst) gnt_vld[m] = 1'b0;
        end
    end

    always_comb begin
        int s;
        s        = 0;
        rid_m    = '0;
        rdata_m  = '0;
        rresp_m  = '0;
        rlast_m  = '0;
        rvalid_m = '0;
        rdy_s    = '0;
        busy_s   = '0;
        hs_last  = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (gnt_vld[m]) begin
                s = int'(gnt_slv[m]);
                rid_m[m*ID_BITS +: ID_BITS]       = bus.RID_S[s*IDS_BITS +: ID_BITS];
                rdata_m[m*DATA_BITS +: DATA_BITS] = bus.RDATA_S[s*DATA_BITS +: DATA_BITS];
                rresp_m[m*2 +: 2]                 = bus.RRESP_S[s*2 +: 2];
                rlast_m[m]                        = bus.RLAST_S[s];
                rvalid_m[m]                       = bus.RVALID_S[s];
                busy_s[s]                         = 1'b1;
                rdy_s[s]                          = rdy_s[s] | bus.RREADY_M[m];
                hs_last[m] = bus.RVALID_S[s] & bus.RREADY_M[m] & bus.RLAST_S[s];
            end
        end
`ifdef RDR_INVALID_DRAIN_EN
        drain_s = '0;
        for (int k = 0; k < NUM_S; k++) begin
            drain_s[k] = rst & bus.RVALID_S[k] & ~hit_s[k] & ~busy_s[k];
        end
        rdy_s = rdy_s | drain_s;
`endif
    end

    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            st_d[m]   = st_q[m];
            lock_d[m] = lock_q[m];
            rr_d[m]   = rr_q[m];
            if (hs_last[m]) begin
                st_d[m] = IDLE;
                rr_d[m] = (gnt_slv[m] == SW'(NUM_S - 1)) ? '0 : gnt_slv[m] + 1'b1;
            end else if ((st_q[m] == IDLE) && gnt_vld[m]) begin
                st_d[m]   = LOCKED;
                lock_d[m] = gnt_slv[m];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int m = 0; m < NUM_M; m++) begin
                st_q[m]   <= IDLE;
                lock_q[m] <= '0;
                rr_q[m]   <= '0;
            end
`ifdef RDR_INVALID_DRAIN_EN
            rid_err_q <= 1'b0;
`endif
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                st_q[m]   <= st_d[m];
                lock_q[m] <= lock_d[m];
                rr_q[m]   <= rr_d[m];
            end
`ifdef RDR_INVALID_DRAIN_EN
            rid_err_q <= rid_err_q | (|drain_s);
`endif
        end
    end

    assign bus.RREADY_S = rdy_s;
    assign bus.RID_M    = rid_m;
    assign bus.RDATA_M  = rdata_m;
    assign bus.RRESP_M  = rresp_m;
    assign bus.RLAST_M  = rlast_m;
    assign bus.RVALID_M = rvalid_m;
`ifdef RDR_INVALID_DRAIN_EN
    assign bus.rid_err  = rid_err_q;
`else
    assign bus.rid_err  = 1'b0;
`endif
endmodule

// File: tb/tb_read_data_router.sv
// Directed bench for read_data_router: per-slave beat queues drive the slaves, per-master scoreboards
// hold the expected beat order and are checked by a negedge monitor on every master handshake.
module tb_read_data_router;
    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } mexp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nfail = 0;

    beat_t      sq  [6][$];
    mexp_t      exq [3][$];
    logic [5:0] en = 6'b111111;
    logic [5:0] hs;

    read_data_router_if bus ();

    read_data_router dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        mexp_t act;
        mexp_t e;
        for (int m = 0; m < 3; m++) begin
            if (bus.RVALID_M[m] && bus.RREADY_M[m]) begin
                act = {bus.RID_M[m*4 +: 4], bus.RDATA_M[m*32 +: 32], bus.RRESP_M[m*2 +: 2], bus.RLAST_M[m]};
                if (exq[m].size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_beat_m%0d: got %h required none", m, act);
                end else begin
                    e = exq[m].pop_front();
                    chk($sformatf("beat_m%0d", m), 64'(act), 64'(e));
                end
            end
        end
    end

    task automatic drive();
        bus.RID_S    = '0;
        bus.RDATA_S  = '0;
        bus.RRESP_S  = '0;
        bus.RLAST_S  = '0;
        bus.RVALID_S = '0;
        for (int s = 0; s < 6; s++) begin
            if (sq[s].size() > 0 && en[s]) begin
                bus.RID_S[s*8 +: 8]    = sq[s][0].id;
                bus.RDATA_S[s*32 +: 32] = sq[s][0].data;
                bus.RRESP_S[s*2 +: 2]  = sq[s][0].resp;
                bus.RLAST_S[s]         = sq[s][0].last;
                bus.RVALID_S[s]        = 1'b1;
            end
        end
    endtask

    // n beats queued on slave s; the first nexp of them are expected at master m.
    task automatic load(input int s, input logic [7:0] id, input int n, input logic [31:0] base,
                        input int m, input int nexp);
        beat_t b;
        mexp_t e;
        for (int i = 0; i < n; i++) begin
            b.id   = id;
            b.data = base + 32'(i);
            b.resp = i[1:0];
            b.last = (i == n - 1);
            sq[s].push_back(b);
            if (i < nexp) begin
                e.id   = id[3:0];
                e.data = b.data;
                e.resp = b.resp;
                e.last = b.last;
                exq[m].push_back(e);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        hs = bus.RVALID_S & bus.RREADY_S;
        @(posedge clk);
        #1;
        for (int s = 0; s < 6; s++) begin
            if (hs[s] && sq[s].size() > 0) void'(sq[s].pop_front());
        end
        drive();
    endtask

    task automatic step(input logic [5:0] exp_rdy, input string nm);
        settle();
        chk(nm, 64'(bus.RREADY_S), 64'(exp_rdy));
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.RREADY_M = 3'b000;
        load(0, 8'h10, 1, 32'h0000_00A5, 0, 1);
        drive();
        repeat (3) @(posedge clk);
        #1;
        settle();
        chk("rst_rvalid_m", 64'(bus.RVALID_M), 64'h0);
        chk("rst_rready_s", 64'(bus.RREADY_S), 64'h0);
        chk("rst_rid_m",    64'(bus.RID_M),    64'h0);
        chk("rst_rdata_m0", 64'(bus.RDATA_M[31:0]), 64'h0);
        chk("rst_rresp_rlast", 64'({bus.RRESP_M, bus.RLAST_M}), 64'h0);
        chk("rst_rid_err",  64'(bus.rid_err),  64'h0);
        adv();
        rst = 1'b1;
        bus.RREADY_M = 3'b111;
        step(6'b000001, "first_after_rst");

        // Single beat S2 -> M1
        load(2, 8'h23, 1, 32'hCAFE_0001, 1, 1);
        drive();
        settle();
        chk("single_rready_s", 64'(bus.RREADY_S), 64'h04);
        chk("single_rvalid_m", 64'(bus.RVALID_M), 64'h2);
        chk("single_rid_m1",   64'(bus.RID_M[7:4]), 64'h3);
        adv();
        settle();
        chk("single_rr_ptr1", 64'(dut.rr_q[1]), 64'h3);
        chk("single_idle_m1", 64'(dut.st_q[1]), 64'h0);
        adv();

        // Burst lock: S1 4 beats to M0, S5 joins from beat 2
        load(1, 8'h15, 4, 32'h1000_0000, 0, 4);
        load(5, 8'h17, 1, 32'h5000_0000, 0, 1);
        en[5] = 1'b0;
        drive();
        settle();
        chk("lock_b0", 64'(bus.RREADY_S), 64'h02);
        en[5] = 1'b1;
        adv();
        step(6'b000010, "lock_b1");
        step(6'b000010, "lock_b2");
        step(6'b000010, "lock_b3");
        step(6'b100000, "lock_s5");
        step(6'b000000, "lock_done");

        // Round robin on M2
        load(0, 8'h40, 1, 32'h4000_0000, 2, 1);
        load(3, 8'h43, 1, 32'h4300_0000, 2, 1);
        load(4, 8'h44, 1, 32'h4400_0000, 2, 1);
        drive();
        step(6'b000001, "rr_s0");
        step(6'b001000, "rr_s3");
        step(6'b010000, "rr_s4");
        step(6'b000000, "rr_done");

        // Parallel masters with backpressure on M0
        load(2, 8'h12, 4, 32'h2000_0000, 0, 4);
        load(5, 8'h25, 4, 32'h5500_0000, 1, 4);
        drive();
        step(6'b100100, "par_c0");
        bus.RREADY_M = 3'b110;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("par_stall_rready_s", 64'(bus.RREADY_S), 64'h20);
            chk("par_stall_rdata_m0", 64'(bus.RDATA_M[31:0]), 64'h2000_0001);
            chk("par_stall_rvalid_m0", 64'(bus.RVALID_M[0]), 64'h1);
            adv();
        end
        bus.RREADY_M = 3'b111;
        step(6'b000100, "par_c4");
        step(6'b000100, "par_c5");
        step(6'b000100, "par_c6");
        step(6'b000000, "par_done");

        // Invalid master field on S4
        load(4, 8'h02, 1, 32'hBAD0_0000, 0, 0);
        drive();
        settle();
`ifdef RDR_INVALID_DRAIN_EN
        chk("inv_rready_s", 64'(bus.RREADY_S), 64'h10);
`else
        chk("inv_rready_s", 64'(bus.RREADY_S), 64'h00);
`endif
        chk("inv_rvalid_m", 64'(bus.RVALID_M), 64'h0);
        adv();
        settle();
`ifdef RDR_INVALID_DRAIN_EN
        chk("inv_rid_err", 64'(bus.rid_err), 64'h1);
`else
        chk("inv_rid_err", 64'(bus.rid_err), 64'h0);
`endif
        chk("inv_rvalid_m2", 64'(bus.RVALID_M), 64'h0);
        adv();
        sq[4].delete();
        drive();

        // Reset in the middle of an S1 -> M0 burst
        load(1, 8'h15, 4, 32'h1100_0000, 0, 2);
        drive();
        step(6'b000010, "rstmid_b0");
        step(6'b000010, "rstmid_b1");
        rst = 1'b0;
        settle();
        chk("rstmid_rvalid_m", 64'(bus.RVALID_M), 64'h0);
        chk("rstmid_rready_s", 64'(bus.RREADY_S), 64'h0);
        chk("rstmid_rdata_m0", 64'(bus.RDATA_M[31:0]), 64'h0);
        chk("rstmid_rid_m",    64'(bus.RID_M), 64'h0);
        adv();
        sq[1].delete();
        drive();
        settle();
        chk("rstmid_idle_m0", 64'(dut.st_q[0]), 64'h0);
        chk("rstmid_rr_ptr0", 64'(dut.rr_q[0]), 64'h0);
        chk("rstmid_rid_err", 64'(bus.rid_err), 64'h0);
        adv();
        rst = 1'b1;
        load(1, 8'h1A, 1, 32'h1A00_0000, 0, 1);
        load(3, 8'h1B, 1, 32'h3300_0000, 0, 1);
        drive();
        step(6'b000010, "post_rst_s1");
        step(6'b001000, "post_rst_s3");
        step(6'b000000, "post_rst_done");

        for (int m = 0; m < 3; m++) begin
            chk($sformatf("pending_m%0d", m), 64'(exq[m].size()), 64'h0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
